// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Fetch-stage producer for the F/D interface. Owns the program counter,
// presents the instruction-memory address, and loads the F/D latch with the
// fetched instruction word and its PC. Consumes a decode-stage redirect and a
// higher-priority execute-stage redirect. Both redirects flush the F/D latch
// with an all-zero bubble.
//
// Parameters:
//   RESET_PC  PC loaded while reset is asserted.
//   IMEM_AW   width of address_imem (low IMEM_AW bits of the PC).
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset (0 = in reset)
//   address_imem   instruction-memory address, pc[IMEM_AW-1:0]
//   q_imem         instruction word at address_imem (same-cycle)
//   stall          hazard hold from decode
//   decRedirect    decode-stage jump/branch taken
//   decTarget      decode-stage redirect target
//   exRedirect     execute-stage redirect (jr / mispredict), highest priority
//   exTarget       execute-stage redirect target
//   fdInstruction  F/D latch instruction word
//   fdPc           PC of fdInstruction
//   fdValid        F/D latch holds a real instruction
//   pc             current fetch PC
//   fetchCount     number of valid instructions loaded into F/D (mod 2^32)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IMEM_AW-1:0] address_imem,
  input  logic [31:0]        q_imem,
  input  logic               stall,
  input  logic               decRedirect,
  input  logic [31:0]        decTarget,
  input  logic               exRedirect,
  input  logic [31:0]        exTarget,
  output logic [31:0]        fdInstruction,
  output logic [31:0]        fdPc,
  output logic               fdValid,
  output logic [31:0]        pc,
  output logic [31:0]        fetchCount
);

  localparam int DATA_W = 32;

  // What the current edge does, in priority order.
  typedef enum logic [1:0] {
    ACT_SEQ  = 2'd0,
    ACT_HOLD = 2'd1,
    ACT_DEC  = 2'd2,
    ACT_EX   = 2'd3
  } action_t;

  action_t           action;
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] count;

  // 32-bit modulo increment; all-ones wraps to zero.
  function automatic logic [DATA_W-1:0] incWrap(input logic [DATA_W-1:0] v);
    return v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // A decode redirect is only meaningful when the instruction that produced
  // it (sitting in F/D) is real; a bubble cannot branch. A stall suppresses
  // it entirely because decode re-asserts it once the hazard clears.
  always_comb begin
    action = ACT_SEQ;
    if (exRedirect) begin
      action = ACT_EX;
    end else if (stall) begin
      action = ACT_HOLD;
    end else if (decRedirect && vld_p1) begin
      action = ACT_DEC;
    end
  end

  // ---- Stage p0: fetch PC ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_p0 <= RESET_PC;
    end else begin
      case (action)
        ACT_EX:   pc_p0 <= exTarget;
        ACT_HOLD: pc_p0 <= pc_p0;
        ACT_DEC:  pc_p0 <= decTarget;
        default:  pc_p0 <= incWrap(pc_p0);
      endcase
    end
  end

  // ---- Stage p1: F/D latch ----
  // On either redirect the word on q_imem is wrong-path, so a zero bubble is
  // loaded instead. The fetch counter only moves on real loads and is never
  // rolled back by a later flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      count    <= '0;
    end else begin
      case (action)
        ACT_EX, ACT_DEC: begin
          instr_p1 <= '0;
          pc_p1    <= '0;
          vld_p1   <= 1'b0;
        end
        ACT_HOLD: begin
          instr_p1 <= instr_p1;
          pc_p1    <= pc_p1;
          vld_p1   <= vld_p1;
        end
        default: begin
          instr_p1 <= q_imem;
          pc_p1    <= pc_p0;
          vld_p1   <= 1'b1;
          count    <= incWrap(count);
        end
      endcase
    end
  end

  // Targets are kept at full width; only the memory address aliases.
  assign address_imem  = pc_p0[IMEM_AW-1:0];
  assign pc            = pc_p0;
  assign fdInstruction = instr_p1;
  assign fdPc          = pc_p1;
  assign fdValid       = vld_p1;
  assign fetchCount    = count;

endmodule
